// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

   localparam int unsigned ARB_DEFAULT_N        = 4;
   localparam int unsigned ARB_DEFAULT_MAX_HOLD = 16;
   localparam int unsigned ARB_MAX_N            = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Caller slices the result down to its own requester count.
   function automatic logic [ARB_MAX_N-1:0] onehot(input int unsigned idx);
      onehot = ARB_MAX_N'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotated priority encoder: first set req bit at or after ptr, wrapping mod N.
module rr_pick
   import arb_pkg::*;
#(
   parameter int unsigned N = ARB_DEFAULT_N
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 pick_valid,
   output logic [$clog2(N)-1:0] pick_id
);

   localparam int unsigned IW = $clog2(N);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [IW-1:0]  idx;

   assign dbl = {req, req} >> ptr;
   assign rot = dbl[N-1:0];

   // Lowest set bit of the rotated vector wins.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) idx = IW'(i);
      end
   end

   assign pick_valid = |req;
   // N is a power of two, so the IW-bit add wraps mod N.
   assign pick_id    = ptr + idx;

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with grant hold, rotating priority and hold timeout.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned N        = ARB_DEFAULT_N,
   parameter int unsigned MAX_HOLD = ARB_DEFAULT_MAX_HOLD
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic                 en,
   input  logic                 done,
   output logic [N-1:0]         gnt,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 timeout
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
   localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   arb_state_t    state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic          gnt_valid_q, gnt_valid_d;
   logic [IW-1:0] gnt_id_q, gnt_id_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] hold_q, hold_d;
   logic          timeout_q, timeout_d;

   logic          hold_limit_c;
   logic          rel_c;
   logic [IW-1:0] ptr_next_c;
   logic [IW-1:0] pick_ptr_c;
   logic          pick_valid_c;
   logic [IW-1:0] pick_id_c;

   assign hold_limit_c = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
   assign rel_c        = (state_q == GRANT) && (done || !req[gnt_id_q] || hold_limit_c);
   assign ptr_next_c   = gnt_id_q + IW'(1);
   // On a release the pick already sees the rotated pointer, enabling zero-bubble handoff.
   assign pick_ptr_c   = rel_c ? ptr_next_c : ptr_q;

   rr_pick #(.N(N)) u_pick (
      .req        (req),
      .ptr        (pick_ptr_c),
      .pick_valid (pick_valid_c),
      .pick_id    (pick_id_c)
   );

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (en && pick_valid_c) begin
               state_d  = GRANT;
               gnt_d    = N'(onehot(32'(pick_id_c)));
               gnt_id_d = pick_id_c;
               hold_d   = '0;
            end
         end
         GRANT: begin
            if (rel_c) begin
               ptr_d     = ptr_next_c;
               timeout_d = hold_limit_c && !done && req[gnt_id_q];
               if (en && pick_valid_c) begin
                  gnt_d    = N'(onehot(32'(pick_id_c)));
                  gnt_id_d = pick_id_c;
                  hold_d   = '0;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end else if (hold_q != '1) begin
               hold_d = hold_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      gnt_valid_d = |gnt_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         ptr_q       <= '0;
         hold_q      <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
         timeout_q   <= timeout_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;
   assign timeout   = timeout_q;

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Registered round-robin arbiter that shares one resource among N requesters with grant hold, rotating priority and a hold-timeout watchdog. It is the sequential successor to the combinational priority selectors. It sits between requesting units and the shared datapath resource. The granted unit keeps ownership until it signals completion, drops its request, or times out.

## Interface
- `N`, default 4: number of requesters; power of 2, ≥2.
- `MAX_HOLD`, default 16: maximum grant length in cycles; 0 disables the timeout.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  N  request vector; bit i is requester i.
- `en`  in  1  allows new grants; it does not revoke a grant already held.
- `done`  in  1  the current owner has finished; ignored when idle.
- `gnt`  out  N  registered one-hot grant; all zeros when idle.
- `gnt_valid`  out  1  equals |gnt.
- `gnt_id`  out  $clog2(N)  index of the granted requester; holds its last value when idle.
- `timeout`  out  1  one-cycle pulse after a forced release.

## Operation
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, timeout=0, ptr=0 (requester 0 has highest priority), hold_cnt=0, state IDLE.
- Pick rule: scan ptr, ptr+1, …, ptr+N-1 (mod N) and take the first index whose req bit is set.
- FSM states: IDLE and GRANT.
- IDLE:
  - If en && |req: on the next edge go to GRANT, gnt=onehot(pick), gnt_id=pick, hold_cnt=0.
  - Otherwise stay in IDLE.
  - done is ignored.
- GRANT release condition, rel = done || !req[gnt_id] || (MAX_HOLD≠0 && hold_cnt==MAX_HOLD-1).
- GRANT without rel: hold gnt and increment hold_cnt. It cannot overflow, because rel fires first; with MAX_HOLD=0 it saturates.
- GRANT with rel:
  - ptr ← gnt_id+1 mod N.
  - The pick is re-evaluated in the same cycle using the new ptr, over all req bits.
  - If en && any req: regrant on the same edge with zero bubble, hold_cnt=0, stay in GRANT.
  - Otherwise: gnt=0, go to IDLE.
- The releasing requester becomes lowest priority, but it is re-granted if it is the only requester.
- timeout is registered. It is 1 in the cycle after a release caused only by the hold limit (done=0 and req still high). It is 0 otherwise.
- Simultaneous events:
  - done together with the timeout limit counts as a normal release, so timeout=0.
  - en falling during GRANT keeps the current grant. The next release goes to IDLE.

## Timing
- Latency from req to gnt is 1 cycle. gnt is never combinationally dependent on the inputs.
- A grant lasts at least 1 cycle and at most MAX_HOLD cycles.
- Back-to-back handoff: gnt moves from one requester to the next in consecutive cycles with no idle cycle.
- Reset asserted mid-grant: the next edge restores every reset value. No timeout pulse is produced.
- ptr changes only on a release edge. It does not change on a grant from IDLE.

## Structure
- Package `arb_pkg`:
  - `arb_state_t` enum {IDLE, GRANT}.
  - Default constants for N and MAX_HOLD.
  - Helper function `onehot(idx)`.
- Sub-module `rr_pick`: a combinational rotated priority encoder. Inputs are req[N-1:0] and ptr. Outputs are pick_valid and pick_id. It rotates req by ptr, runs a fixed priority encoder, then rotates the result back.
- Top level: the FSM, ptr, hold_cnt, and the gnt/gnt_id/timeout registers.

## Test plan
1. Reset, then req=1111, en=1, done=1 every cycle → gnt=0001, 0010, 0100, 1000, 0001 on consecutive cycles, with no zero cycle.
2. After reset, req=0100 alone → gnt=0100 and gnt_id=2 one cycle later. Pulse done → next grant uses ptr=3. Then req=1111 gives gnt=1000.
3. MAX_HOLD=16, req=0011 held, done=0 → gnt=0001 for exactly 16 cycles. Then gnt=0010 with timeout=1 for one cycle.
4. en=0, req=1111 for 10 cycles → gnt=0 throughout. Raise en → gnt=0001 on the next edge. Drop en while granted → grant held until done, then gnt=0.
5. Owner drops req: gnt=0010, req goes 0110→0100 → gnt=0100 on the next cycle, timeout=0.
6. Reset pulsed while gnt=1000 with hold_cnt=7 → next cycle gnt=0, gnt_valid=0, timeout=0. Then req=1111 gives gnt=0001, confirming ptr=0.
